// File: rtl/mips_pipe_pkg.sv
// Shared pipeline defaults and the register-update mode used by the forwarding mux register.
package mips_pipe_pkg;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned FWD_CNT_W = 16;

  typedef enum logic [1:0] {
    REG_LOAD  = 2'd0,
    REG_STALL = 2'd1,
    REG_FLUSH = 2'd2
  } reg_op_e;

  // Flush beats stall beats load.
  function automatic reg_op_e reg_op(input logic flush, input logic stall);
    reg_op_e op;
    if (flush)      op = REG_FLUSH;
    else if (stall) op = REG_STALL;
    else            op = REG_LOAD;
    return op;
  endfunction

endpackage

// File: rtl/mux_nin.sv
// Combinational N-way source select; out-of-range selects fall onto the last source.
module mux_nin #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned NUM_IN = 4
) (
  input  logic [NUM_IN*WIDTH-1:0]     in_bus,
  input  logic [$clog2(NUM_IN)-1:0]   sel,
  output logic [WIDTH-1:0]            out
);

  localparam int unsigned SEL_W = $clog2(NUM_IN);

  // Last source is the default, which also covers every sel >= NUM_IN.
  always_comb begin
    out = in_bus[(NUM_IN-1)*WIDTH +: WIDTH];
    for (int k = 0; k < int'(NUM_IN) - 1; k++) begin
      if (sel == SEL_W'(k)) out = in_bus[k*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/fwd_mux_reg.sv
// Registered forwarding mux with flush/stall priority, sticky select error and saturating use count.
module fwd_mux_reg
  import mips_pipe_pkg::*;
#(
  parameter int unsigned WIDTH  = DATA_W,
  parameter int unsigned NUM_IN = 4,
  parameter int unsigned SEL_W  = $clog2(NUM_IN),
  parameter int unsigned CNT_W  = FWD_CNT_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_bus,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  input  logic                    stall,
  input  logic                    flush,
  input  logic                    err_clr,
  output logic [WIDTH-1:0]        out,
  output logic                    out_valid,
  output logic                    sel_err,
  output logic [CNT_W-1:0]        fwd_cnt
);

  logic [WIDTH-1:0] mux_out_c;
  logic             sel_oob_c;
  logic             accept_c;
  reg_op_e          op_c;

  logic [WIDTH-1:0] out_d;
  logic             out_valid_d;
  logic             sel_err_d;
  logic [CNT_W-1:0] fwd_cnt_d;

  mux_nin #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN)
  ) u_mux (
    .in_bus (in_bus),
    .sel    (sel),
    .out    (mux_out_c)
  );

  // A full power-of-two select range has no out-of-range codes.
  if ((1 << SEL_W) == NUM_IN) begin : g_sel_full
    assign sel_oob_c = 1'b0;
  end else begin : g_sel_partial
    assign sel_oob_c = (sel >= SEL_W'(NUM_IN));
  end

  assign op_c     = reg_op(flush, stall);
  assign accept_c = (op_c == REG_LOAD) && in_valid;

  // Next-state selection; err_clr acts regardless of mode but loses to a same-edge set.
  always_comb begin
    out_d       = out;
    out_valid_d = out_valid;
    sel_err_d   = sel_err;
    fwd_cnt_d   = fwd_cnt;

    case (op_c)
      REG_FLUSH: begin
        out_d       = '0;
        out_valid_d = 1'b0;
      end
      REG_LOAD: begin
        out_d       = mux_out_c;
        out_valid_d = in_valid;
      end
      default: ;
    endcase

    if (accept_c && (sel != '0) && (fwd_cnt != '1)) fwd_cnt_d = fwd_cnt + CNT_W'(1);

    if (err_clr)               sel_err_d = 1'b0;
    if (accept_c && sel_oob_c) sel_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out       <= '0;
      out_valid <= 1'b0;
      sel_err   <= 1'b0;
      fwd_cnt   <= '0;
    end else begin
      out       <= out_d;
      out_valid <= out_valid_d;
      sel_err   <= sel_err_d;
      fwd_cnt   <= fwd_cnt_d;
    end
  end

endmodule

// File: tb/tb_fwd_mux_reg.sv
// Self-checking bench: a 4-source/16-bit-count instance and a 3-source/4-bit-count instance share stimulus.
module tb_fwd_mux_reg;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] bus;
  logic [1:0]   sel;
  logic         in_valid, stall, flush, err_clr;

  logic [31:0] out4, out3;
  logic        v4, v3, e4, e3;
  logic [15:0] c4;
  logic [3:0]  c3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fwd_mux_reg #(.WIDTH(32), .NUM_IN(4), .CNT_W(16)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_bus(bus), .sel(sel), .in_valid(in_valid),
    .stall(stall), .flush(flush), .err_clr(err_clr),
    .out(out4), .out_valid(v4), .sel_err(e4), .fwd_cnt(c4));

  fwd_mux_reg #(.WIDTH(32), .NUM_IN(3), .CNT_W(4)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_bus(bus[95:0]), .sel(sel), .in_valid(in_valid),
    .stall(stall), .flush(flush), .err_clr(err_clr),
    .out(out3), .out_valid(v3), .sel_err(e3), .fwd_cnt(c3));

  // Reference model: index 0 = 4-source instance, index 1 = 3-source instance.
  int          m_n[2]   = '{4, 3};
  int          m_max[2] = '{65535, 15};
  logic [31:0] m_out[2];
  logic        m_v[2], m_err[2];
  int          m_cnt[2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_out[i] = '0; m_v[i] = 1'b0; m_err[i] = 1'b0; m_cnt[i] = 0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      int  s;
      logic set;
      s   = int'(sel);
      set = 1'b0;
      if (flush) begin
        m_out[i] = '0; m_v[i] = 1'b0;
      end else if (!stall) begin
        m_out[i] = bus[((s < m_n[i]) ? s : m_n[i] - 1) * 32 +: 32];
        m_v[i]   = in_valid;
        if (in_valid) begin
          if (s != 0 && m_cnt[i] < m_max[i]) m_cnt[i]++;
          if (s >= m_n[i]) set = 1'b1;
        end
      end
      if (set)          m_err[i] = 1'b1;
      else if (err_clr) m_err[i] = 1'b0;
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    sel = 2'd0; in_valid = 1'b0; stall = 1'b0; flush = 1'b0; err_clr = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_sources();
    bus = {32'h44, 32'h33, 32'h22, 32'h11};
  endtask

  typedef struct {
    logic [1:0]  sel;
    logic        v, st, fl, clr;
    logic [31:0] o4;
    logic        v4;
    logic [15:0] c4;
    logic [31:0] o3;
    logic        e3;
  } vec_t;

  vec_t tbl[11];

  initial begin
    tbl[0]  = '{2'd0, 1, 0, 0, 0, 32'h11, 1, 16'd0, 32'h11, 0};
    tbl[1]  = '{2'd1, 1, 0, 0, 0, 32'h22, 1, 16'd1, 32'h22, 0};
    tbl[2]  = '{2'd2, 1, 0, 0, 0, 32'h33, 1, 16'd2, 32'h33, 0};
    tbl[3]  = '{2'd3, 1, 0, 0, 0, 32'h44, 1, 16'd3, 32'h33, 1};
    tbl[4]  = '{2'd0, 0, 0, 0, 0, 32'h11, 0, 16'd3, 32'h11, 1};
    tbl[5]  = '{2'd0, 0, 0, 0, 0, 32'h11, 0, 16'd3, 32'h11, 1};
    tbl[6]  = '{2'd0, 0, 0, 0, 0, 32'h11, 0, 16'd3, 32'h11, 1};
    tbl[7]  = '{2'd0, 0, 0, 0, 1, 32'h11, 0, 16'd3, 32'h11, 0};
    tbl[8]  = '{2'd3, 1, 0, 0, 1, 32'h44, 1, 16'd4, 32'h33, 1};
    tbl[9]  = '{2'd0, 0, 1, 0, 1, 32'h44, 1, 16'd4, 32'h33, 0};
    tbl[10] = '{2'd2, 1, 1, 1, 0, 32'h00, 0, 16'd4, 32'h00, 0};

    idle_inputs();
    bus = '0;
    do_reset();
    #1;
    chk("reset_out", {32'h0, out4}, 64'h0);
    chk("reset_valid", {63'h0, v4}, 64'h0);
    chk("reset_cnt", {48'h0, c4}, 64'h0);
    chk("reset_err", {63'h0, e3}, 64'h0);

    // Directed table: decode, clamp, sticky error, clear, set-wins, stall, flush.
    set_sources();
    for (int i = 0; i < 11; i++) begin
      sel = tbl[i].sel; in_valid = tbl[i].v; stall = tbl[i].st;
      flush = tbl[i].fl; err_clr = tbl[i].clr;
      tick();
      chk($sformatf("tbl%0d_out4", i), {32'h0, out4}, {32'h0, tbl[i].o4});
      chk($sformatf("tbl%0d_v4", i), {63'h0, v4}, {63'h0, tbl[i].v4});
      chk($sformatf("tbl%0d_cnt4", i), {48'h0, c4}, {48'h0, tbl[i].c4});
      chk($sformatf("tbl%0d_out3", i), {32'h0, out3}, {32'h0, tbl[i].o3});
      chk($sformatf("tbl%0d_err3", i), {63'h0, e3}, {63'h0, tbl[i].e3});
      chk($sformatf("tbl%0d_err4", i), {63'h0, e4}, 64'h0);
    end

    // Stall holds through changing sources; flush wins over stall.
    idle_inputs();
    do_reset();
    bus = {32'h0, 32'h0, 32'hAAAA_AAAA, 32'h0};
    sel = 2'd1; in_valid = 1'b1;
    tick();
    chk("stall_load", {32'h0, out4}, 64'hAAAA_AAAA);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus = {$urandom, $urandom, $urandom, $urandom};
      sel = 2'($urandom_range(0, 3));
      tick();
      chk($sformatf("stall_hold%0d_out", i), {32'h0, out4}, 64'hAAAA_AAAA);
      chk($sformatf("stall_hold%0d_v", i), {63'h0, v4}, 64'h1);
    end
    flush = 1'b1;
    tick();
    chk("stall_flush_out", {32'h0, out4}, 64'h0);
    chk("stall_flush_v", {63'h0, v4}, 64'h0);

    // Counter saturation on the 4-bit instance; sel=0 never counts.
    idle_inputs();
    do_reset();
    set_sources();
    sel = 2'd1; in_valid = 1'b1;
    repeat (20) tick();
    chk("sat_cnt3", {60'h0, c3}, 64'd15);
    chk("sat_cnt4", {48'h0, c4}, 64'd20);
    sel = 2'd0;
    repeat (5) tick();
    chk("sel0_cnt3", {60'h0, c3}, 64'd15);
    chk("sel0_cnt4", {48'h0, c4}, 64'd20);

    // Asynchronous reset mid-cycle, then the basic decode sequence again.
    sel = 2'd2;
    tick();
    chk("pre_rst_v", {63'h0, v4}, 64'h1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst_out", {32'h0, out4}, 64'h0);
    chk("async_rst_v", {63'h0, v4}, 64'h0);
    chk("async_rst_cnt4", {48'h0, c4}, 64'h0);
    chk("async_rst_cnt3", {60'h0, c3}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      sel = 2'(k);
      tick();
      chk($sformatf("post_rst_out%0d", k), {32'h0, out4}, 64'(32'h11 * (k + 1)));
    end
    chk("post_rst_cnt4", {48'h0, c4}, 64'd3);

    // Random stimulus against the model.
    idle_inputs();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      bus      = {$urandom, $urandom, $urandom, $urandom};
      sel      = 2'($urandom_range(0, 3));
      in_valid = ($urandom_range(0, 3) != 0);
      stall    = ($urandom_range(0, 3) == 0);
      flush    = ($urandom_range(0, 7) == 0);
      err_clr  = ($urandom_range(0, 7) == 0);
      tick();
      chk("rnd_out4", {32'h0, out4}, {32'h0, m_out[0]});
      chk("rnd_v4", {63'h0, v4}, {63'h0, m_v[0]});
      chk("rnd_e4", {63'h0, e4}, {63'h0, m_err[0]});
      chk("rnd_c4", {48'h0, c4}, 64'(m_cnt[0]));
      chk("rnd_out3", {32'h0, out3}, {32'h0, m_out[1]});
      chk("rnd_v3", {63'h0, v3}, {63'h0, m_v[1]});
      chk("rnd_e3", {63'h0, e3}, {63'h0, m_err[1]});
      chk("rnd_c3", {60'h0, c3}, 64'(m_cnt[1]));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fwd_mux_reg.md
FWD_MUX_REG -- requirements
Module: fwd_mux_reg

Interface
REQ-001 Parameter WIDTH, default 32, data width of each source and of the output.
REQ-002 Parameter NUM_IN, default 4, number of sources, legal range 2..8.
REQ-003 Parameter SEL_W, default $clog2(NUM_IN), select width; not overridden independently.
REQ-004 Parameter CNT_W, default 16, width of the forward-use counter.
REQ-005 clk  input  1  sole clock, rising-edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 in_bus  input  NUM_IN*WIDTH  packed sources; source k occupies bits [k*WIDTH +: WIDTH].
REQ-008 sel  input  SEL_W  source select.
REQ-009 in_valid  input  1  qualifies sel/in_bus this cycle.
REQ-010 stall  input  1  hold output register contents.
REQ-011 flush  input  1  invalidate output register (pipeline bubble).
REQ-012 err_clr  input  1  clears sticky select error.
REQ-013 out  output  WIDTH  registered selected data.
REQ-014 out_valid  output  1  out holds a valid selection.
REQ-015 sel_err  output  1  sticky flag: out-of-range sel was accepted.
REQ-016 fwd_cnt  output  CNT_W  saturating count of accepted selections with sel != 0.

Function
REQ-017 Latency is exactly one clock: data selected at edge N appears on out after edge N.
REQ-018 Source decode: sel = k with k < NUM_IN selects source k; sel >= NUM_IN selects source NUM_IN-1.
REQ-019 Per-edge priority: flush > stall > load.
REQ-020 Flush: out <= 0, out_valid <= 0; fwd_cnt and sel_err unchanged by the flush itself.
REQ-021 Stall without flush: out, out_valid, fwd_cnt, sel_err hold (except err_clr, REQ-025).
REQ-022 Load (no flush, no stall): out <= decoded source, out_valid <= in_valid; out updates even when in_valid = 0.
REQ-023 Accepted selection: a load edge with in_valid = 1; only accepted selections affect fwd_cnt and sel_err.
REQ-024 sel_err sets on an accepted selection with sel >= NUM_IN; stays set until err_clr or reset.
REQ-025 err_clr acts in every mode including stall and flush; same-edge set and clear -> set wins.
REQ-026 fwd_cnt increments by 1 on each accepted selection with sel != 0; saturates at 2^CNT_W-1, no wrap.
REQ-027 When NUM_IN is a power of two, sel >= NUM_IN cannot occur and sel_err stays 0.
REQ-028 No combinational path from any input to any output.

Reset
REQ-029 rst_n low asynchronously forces out = 0, out_valid = 0, sel_err = 0, fwd_cnt = 0.
REQ-030 Reset dominates flush, stall, load and err_clr.
REQ-031 Release is synchronous to clk; first load occurs on the first rising edge with rst_n high.
REQ-032 Reset asserted mid-stall discards held data; no state survives reset.

Structure
REQ-033 Shared package mips_pipe_pkg holds the defaults DATA_W = 32 and FWD_CNT_W = 16.
REQ-034 Combinational decode is a sub-module mux_nin (parameters WIDTH, NUM_IN; ports in_bus, sel, out) with REQ-018 clamping.
REQ-035 fwd_mux_reg holds only the registers, priority logic, counter and error flag.

Verification
REQ-036 NUM_IN=4, sources 0x11/0x22/0x33/0x44, sel 0..3 with in_valid=1 on successive edges -> out 0x11, 0x22, 0x33, 0x44 one cycle later each; fwd_cnt = 3.
REQ-037 NUM_IN=3, sel=3, in_valid=1 -> out = source 2, sel_err = 1; three idle cycles -> still 1; err_clr -> 0 next edge.
REQ-038 out = 0xAAAA_AAAA valid, stall=1 for 3 cycles while sources change -> out and out_valid held; stall=1 plus flush=1 -> out = 0, out_valid = 0.
REQ-039 CNT_W=4, 20 accepted selections with sel=1 -> fwd_cnt saturates at 15; sel=0 selections never increment it.
REQ-040 rst_n pulled low mid-cycle with out_valid=1 -> all outputs 0 immediately, before next clk edge; after release, first load behaves per REQ-036.
REQ-041 Same edge: sel=3 accepted (NUM_IN=3) with err_clr=1 -> sel_err = 1.
